// File: rtl/sprite_arbiter_pkg.sv
// Shared constants, types and helpers for the sprite arbiter slice.
package sprite_arbiter_pkg;

  // Number of sprite requesters; the index width below is sized for 8.
  localparam int SPRITE_COUNT = 8;
  localparam int SPRITE_IDX_W = 3;
  localparam int PIXEL_W      = 2;

  // Opaque-pixel encodings.
  // Multicolor sprites are transparent only on this code.
  localparam logic [PIXEL_W-1:0] PIX_TRANSPARENT  = 2'b00;
  // Hi-res sprites are opaque when this pixel bit is set.
  localparam int                 HIRES_OPAQUE_BIT = 1;

  // Dot phase strobe that marks the first tick of a pixel.
  localparam int PIXEL_START_PHASE = 1;

  typedef logic [SPRITE_COUNT-1:0] sprite_mask_t;

  // Winning sprite for the current pixel.
  typedef struct packed {
    logic                    valid;
    logic [SPRITE_IDX_W-1:0] idx;
  } active_sprite_t;

  // True when a sprite pixel covers the background.
  function automatic logic is_opaque(input logic [PIXEL_W-1:0] px, input logic mmc);
    return mmc ? (px != PIX_TRANSPARENT) : px[HIRES_OPAQUE_BIT];
  endfunction

  // True when two or more sprites are opaque on the same pixel.
  function automatic logic multi_hit(input sprite_mask_t m);
    return (m & (m - sprite_mask_t'(1))) != '0;
  endfunction

endpackage

// File: rtl/sprite_arbiter_if.sv
// Pixel-sequencer / register-read bus between the video pipeline and the
// sprite arbiter. The master drives pixel data and read strobes; the slave
// (the arbiter) returns the winning sprite and collision state.
interface sprite_arbiter_if import sprite_arbiter_pkg::*; ();

  logic [3:0]                      dot_rising;
  logic                            stage0;
  logic [SPRITE_COUNT*PIXEL_W-1:0] sprite_cur_pixel_o;
  sprite_mask_t                    sprite_mmc_d;
  logic                            is_background_pixel0;
  logic                            main_border;
  logic                            rd_m2m;
  logic                            rd_m2d;

  logic [3:0]                      active_sprite_d;
  sprite_mask_t                    m2m;
  sprite_mask_t                    m2d;
  logic                            irq_m2m;
  logic                            irq_m2d;

  modport master (
    output dot_rising, stage0, sprite_cur_pixel_o, sprite_mmc_d,
           is_background_pixel0, main_border, rd_m2m, rd_m2d,
    input  active_sprite_d, m2m, m2d, irq_m2m, irq_m2d
  );

  modport slave (
    input  dot_rising, stage0, sprite_cur_pixel_o, sprite_mmc_d,
           is_background_pixel0, main_border, rd_m2m, rd_m2d,
    output active_sprite_d, m2m, m2d, irq_m2m, irq_m2d
  );

endinterface

// File: rtl/sprite_priority_encoder.sv
// Combinational: turns the eight current sprite pixels into an opaque mask
// and picks the lowest-numbered opaque sprite as the winner.
module sprite_priority_encoder import sprite_arbiter_pkg::*; (
  input  logic [SPRITE_COUNT*PIXEL_W-1:0] pixels_i,
  input  sprite_mask_t                    mmc_i,
  output sprite_mask_t                    opaque_o,
  output active_sprite_t                  winner_o
);

  // Per-sprite opacity; sprite 0 sits in the most significant pixel slot.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    opaque_o = '0;
    for (int i = 0; i < SPRITE_COUNT; i++) begin
      opaque_o[i] = is_opaque(pixels_i[(SPRITE_COUNT-1-i)*PIXEL_W +: PIXEL_W], mmc_i[i]);
    end
  end

  // Lowest index wins: scan downward so the last hit is the lowest one.
  always_comb begin
    winner_o = '0;
    for (int i = SPRITE_COUNT - 1; i >= 0; i--) begin
      if (opaque_o[i]) begin
        winner_o.valid = 1'b1;
        winner_o.idx   = SPRITE_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/sprite_arbiter.sv
// Sprite arbiter: latches the opaque mask and winning sprite at the start of
// each pixel, then accumulates sprite-sprite and sprite-data collisions one
// clock later (stage0), with read-to-clear registers and first-hit irqs.
module sprite_arbiter import sprite_arbiter_pkg::*; #(
  parameter int NUM_SPRITES = SPRITE_COUNT
) (
  input  logic               clk_dot4x,
  input  logic               rst_n,
  sprite_arbiter_if.slave    bus
);

  // Pixel-start capture.
  logic [NUM_SPRITES-1:0] mask_q,   mask_d;
  logic                   border_q, border_d;
  active_sprite_t         active_q, active_d;

  // Collision registers and interrupt pulses.
  sprite_mask_t           m2m_q,     m2m_d;
  sprite_mask_t           m2d_q,     m2d_d;
  logic                   irq_m2m_q, irq_m2m_d;
  logic                   irq_m2d_q, irq_m2d_d;

  // Combinational helpers.
  sprite_mask_t           opaque_now;
  active_sprite_t         winner_now;
  sprite_mask_t           new_m2m, new_m2d;
  sprite_mask_t           keep_m2m, keep_m2d;
  logic                   pixel_start;
  logic                   unused_phase;

  assign pixel_start  = bus.dot_rising[PIXEL_START_PHASE];
  // The other dot phases are not needed by the arbiter.
  assign unused_phase = ^{bus.dot_rising[3:2], bus.dot_rising[0]};

  sprite_priority_encoder u_prio (
    .pixels_i (bus.sprite_cur_pixel_o),
    .mmc_i    (bus.sprite_mmc_d),
    .opaque_o (opaque_now),
    .winner_o (winner_now)
  );

  // Capture mask, border and winner on the first tick of each pixel; hold otherwise.
  always_comb begin
    mask_d   = mask_q;
    border_d = border_q;
    active_d = active_q;
    if (pixel_start) begin
      mask_d   = opaque_now;
      border_d = bus.main_border;
      active_d = winner_now;
    end
  end

  // New collision bits exist only in the stage0 clock, from the captured mask.
  always_comb begin
    new_m2m = '0;
    new_m2d = '0;
    if (bus.stage0) begin
      if (multi_hit(mask_q)) begin
        new_m2m = mask_q;
      end
      if (!bus.is_background_pixel0 && !border_q) begin
        new_m2d = mask_q;
      end
    end
  end

  // A read wipes old bits but keeps this clock's new bits; irq fires only when
  // a previously empty (or just-cleared) register picks up its first bits.
  always_comb begin
    keep_m2m  = bus.rd_m2m ? '0 : m2m_q;
    keep_m2d  = bus.rd_m2d ? '0 : m2d_q;
    m2m_d     = keep_m2m | new_m2m;
    m2d_d     = keep_m2d | new_m2d;
    irq_m2m_d = (keep_m2m == '0) && (new_m2m != '0);
    irq_m2d_d = (keep_m2d == '0) && (new_m2d != '0);
  end

  // State registers; reset clears everything at once.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      mask_q    <= '0;
      border_q  <= 1'b0;
      active_q  <= '0;
      m2m_q     <= '0;
      m2d_q     <= '0;
      irq_m2m_q <= 1'b0;
      irq_m2d_q <= 1'b0;
    end else begin
      mask_q    <= mask_d;
      border_q  <= border_d;
      active_q  <= active_d;
      m2m_q     <= m2m_d;
      m2d_q     <= m2d_d;
      irq_m2m_q <= irq_m2m_d;
      irq_m2d_q <= irq_m2d_d;
    end
  end

  assign bus.active_sprite_d = active_q;
  assign bus.m2m             = m2m_q;
  assign bus.m2d             = m2d_q;
  assign bus.irq_m2m         = irq_m2m_q;
  assign bus.irq_m2d         = irq_m2d_q;

endmodule

// File: tb/tb_sprite_arbiter.sv
// Directed bench for sprite_arbiter with a pixel-level reference model and a
// per-cycle compare process, plus literal expectations for key scenarios.
module tb_sprite_arbiter;

  logic clk_dot4x = 1'b0;
  logic rst_n     = 1'b0;

  sprite_arbiter_if bus ();

  sprite_arbiter #(.NUM_SPRITES(8)) dut (
    .clk_dot4x (clk_dot4x),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  always #5 clk_dot4x = ~clk_dot4x;

  int tests = 0;
  int fails = 0;

  // Stimulus state: per-sprite pixel, multicolor enables, border, background.
  logic [1:0] pix [8];
  logic [7:0] mmc;
  logic       border;
  logic       bg;

  // Reference model of the visible outputs.
  logic [7:0] m_mask;
  logic       m_border;
  logic [3:0] m_active;
  logic [7:0] m_m2m, m_m2d;
  logic       m_irq_m2m, m_irq_m2d;

  bit cmp_en = 1'b0;
  int irq_seen_m2m;
  int irq_seen_m2d;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_zero();
    m_mask    = '0;
    m_border  = 1'b0;
    m_active  = '0;
    m_m2m     = '0;
    m_m2d     = '0;
    m_irq_m2m = 1'b0;
    m_irq_m2d = 1'b0;
  endtask

  function automatic logic [15:0] flat_pixels();
    logic [15:0] f;
    f = '0;
    for (int i = 0; i < 8; i++) f[15-2*i -: 2] = pix[i];
    return f;
  endfunction

  function automatic logic sprite_opaque(input int i);
    if (mmc[i]) return pix[i] != 2'b00;
    return pix[i] == 2'b10 || pix[i] == 2'b11;
  endfunction

  // One clock: drive inputs (called just after a negedge), predict, advance.
  task automatic step(input logic [3:0] dr, input logic s0, input logic rdm, input logic rdd);
    logic [7:0] mask_now, new_m, new_d, keep_m, keep_d;
    logic [3:0] act_now;
    bus.dot_rising           = dr;
    bus.stage0               = s0;
    bus.sprite_cur_pixel_o   = flat_pixels();
    bus.sprite_mmc_d         = mmc;
    bus.is_background_pixel0 = bg;
    bus.main_border          = border;
    bus.rd_m2m               = rdm;
    bus.rd_m2d               = rdd;

    mask_now = '0;
    act_now  = '0;
    for (int i = 0; i < 8; i++) mask_now[i] = sprite_opaque(i);
    for (int i = 0; i < 8; i++) begin
      if (mask_now[i] && !act_now[3]) act_now = {1'b1, 3'(i)};
    end
    new_m  = (s0 && $countones(m_mask) >= 2) ? m_mask : 8'h00;
    new_d  = (s0 && !bg && !m_border) ? m_mask : 8'h00;
    keep_m = rdm ? 8'h00 : m_m2m;
    keep_d = rdd ? 8'h00 : m_m2d;

    @(posedge clk_dot4x);
    #1;
    if (!rst_n) begin
      model_zero();
    end else begin
      if (dr[1]) begin
        m_mask   = mask_now;
        m_border = border;
        m_active = act_now;
      end
      m_m2m     = keep_m | new_m;
      m_m2d     = keep_d | new_d;
      m_irq_m2m = (keep_m == 0) && (new_m != 0);
      m_irq_m2d = (keep_d == 0) && (new_d != 0);
    end
    if (bus.irq_m2m === 1'b1) irq_seen_m2m++;
    if (bus.irq_m2d === 1'b1) irq_seen_m2d++;
    @(negedge clk_dot4x);
  endtask

  // One full pixel (4 clocks); read strobes land on the given phase (-1 = none).
  task automatic pixel_cycle(input int rdm_ph, input int rdd_ph);
    irq_seen_m2m = 0;
    irq_seen_m2d = 0;
    step(4'b0010, 1'b0, rdm_ph == 0, rdd_ph == 0);
    step(4'b0100, 1'b1, rdm_ph == 1, rdd_ph == 1);
    step(4'b1000, 1'b0, rdm_ph == 2, rdd_ph == 2);
    step(4'b0001, 1'b0, rdm_ph == 3, rdd_ph == 3);
  endtask

  task automatic clear_pix();
    for (int i = 0; i < 8; i++) pix[i] = 2'b00;
    mmc = 8'h00;
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk_dot4x) begin
    if (cmp_en) begin
      check("active_sprite_d", 32'(bus.active_sprite_d), 32'(m_active));
      check("m2m",             32'(bus.m2m),             32'(m_m2m));
      check("m2d",             32'(bus.m2d),             32'(m_m2d));
      check("irq_m2m",         32'(bus.irq_m2m),         32'(m_irq_m2m));
      check("irq_m2d",         32'(bus.irq_m2d),         32'(m_irq_m2d));
    end
  end

  initial begin
    clear_pix();
    border = 1'b0;
    bg     = 1'b1;
    model_zero();
    bus.dot_rising           = '0;
    bus.stage0               = 1'b0;
    bus.sprite_cur_pixel_o   = '0;
    bus.sprite_mmc_d         = '0;
    bus.is_background_pixel0 = 1'b1;
    bus.main_border          = 1'b0;
    bus.rd_m2m               = 1'b0;
    bus.rd_m2d               = 1'b0;
    cmp_en = 1'b1;

    // Reset state, with pixel activity present.
    @(negedge clk_dot4x);
    pix[0] = 2'b11; pix[1] = 2'b11;
    pixel_cycle(-1, -1);
    check("rst_active", 32'(bus.active_sprite_d), 32'h0);
    check("rst_m2m",    32'(bus.m2m), 32'h0);
    check("rst_m2d",    32'(bus.m2d), 32'h0);
    check("rst_irq",    32'({bus.irq_m2m, bus.irq_m2d}), 32'h0);
    rst_n = 1'b1;
    clear_pix();
    pixel_cycle(-1, -1);

    // Sprites 2 and 5 hi-res opaque: winner 2, m2m 0x24, single irq.
    pix[2] = 2'b10; pix[5] = 2'b10;
    irq_seen_m2m = 0;
    step(4'b0010, 1'b0, 1'b0, 1'b0);
    check("s25_active_latency", 32'(bus.active_sprite_d), 32'hA);
    step(4'b0100, 1'b1, 1'b0, 1'b0);
    check("s25_m2m", 32'(bus.m2m), 32'h24);
    check("s25_irq_now", 32'(bus.irq_m2m), 32'h1);
    step(4'b1000, 1'b0, 1'b0, 1'b0);
    check("s25_irq_gone", 32'(bus.irq_m2m), 32'h0);
    step(4'b0001, 1'b0, 1'b0, 1'b0);
    check("s25_irq_pulses", irq_seen_m2m, 1);
    check("s25_m2d_bg", 32'(bus.m2d), 32'h0);

    // Repeat collision while register set: no further irq.
    pixel_cycle(-1, -1);
    check("s25_repeat_irq", irq_seen_m2m, 0);
    check("s25_repeat_m2m", 32'(bus.m2m), 32'h24);

    // Read in the same clock as a new collision on sprites 0,1.
    clear_pix();
    pix[0] = 2'b10; pix[1] = 2'b11;
    pixel_cycle(1, -1);
    check("rd_coll_m2m", 32'(bus.m2m), 32'h03);
    check("rd_coll_irq", irq_seen_m2m, 1);
    check("rd_coll_active", 32'(bus.active_sprite_d), 32'h8);

    // Sprite 3 multicolor 01 over foreground: m2d 0x08 with irq.
    clear_pix();
    pix[3] = 2'b01; mmc = 8'h08; bg = 1'b0; border = 1'b0;
    pixel_cycle(-1, -1);
    check("m2d_hit", 32'(bus.m2d), 32'h08);
    check("m2d_irq", irq_seen_m2d, 1);
    check("m2d_active", 32'(bus.active_sprite_d), 32'hB);
    check("m2d_m2m_kept", 32'(bus.m2m), 32'h03);

    // Hi-res 01 is transparent; read m2d with nothing new.
    mmc = 8'h00;
    pixel_cycle(-1, 1);
    check("hires01_active", 32'(bus.active_sprite_d), 32'h0);
    check("hires01_m2d_clr", 32'(bus.m2d), 32'h00);
    check("hires01_irq", irq_seen_m2d, 0);

    // Same sprite under the main border: no sprite-data collision.
    mmc = 8'h08; border = 1'b1;
    pixel_cycle(-1, -1);
    check("border_m2d", 32'(bus.m2d), 32'h00);
    check("border_irq", irq_seen_m2d, 0);
    border = 1'b0;

    // Reads with nothing pending.
    clear_pix();
    pixel_cycle(2, 2);
    check("rd_empty_m2m", 32'(bus.m2m), 32'h00);
    pixel_cycle(2, 2);
    check("rd_empty_irq", irq_seen_m2m + irq_seen_m2d, 0);

    // All eight multicolor opaque.
    for (int i = 0; i < 8; i++) pix[i] = 2'b11;
    mmc = 8'hFF;
    pixel_cycle(-1, -1);
    check("all_active", 32'(bus.active_sprite_d), 32'h8);
    check("all_m2m", 32'(bus.m2m), 32'hFF);
    check("all_m2d", 32'(bus.m2d), 32'hFF);

    // Only sprite 7 opaque: highest index still wins when alone.
    clear_pix();
    pix[7] = 2'b11;
    pixel_cycle(-1, -1);
    check("s7_active", 32'(bus.active_sprite_d), 32'hF);

    // Clear both registers.
    clear_pix();
    pixel_cycle(3, 3);
    check("clr_both", 32'({bus.m2m, bus.m2d}), 32'h0);

    // Reset between pixel start and stage0 with a collision in progress.
    pix[2] = 2'b10; pix[5] = 2'b10;
    step(4'b0010, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    model_zero();
    #1;
    check("midrst_active", 32'(bus.active_sprite_d), 32'h0);
    check("midrst_coll", 32'({bus.m2m, bus.m2d}), 32'h0);
    check("midrst_irq", 32'({bus.irq_m2m, bus.irq_m2d}), 32'h0);
    @(negedge clk_dot4x);
    irq_seen_m2m = 0;
    irq_seen_m2d = 0;
    step(4'b0100, 1'b1, 1'b1, 1'b0);
    step(4'b1000, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(4'b0100, 1'b1, 1'b0, 1'b0);
    check("postrst_noirq", irq_seen_m2m + irq_seen_m2d, 0);
    check("postrst_m2m", 32'(bus.m2m), 32'h0);
    pixel_cycle(-1, -1);
    check("postrst_irq", irq_seen_m2m, 1);
    check("postrst_m2m_hit", 32'(bus.m2m), 32'h24);
    check("postrst_m2d_hit", 32'(bus.m2d), 32'h24);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
